// File: rtl/filter_pkg.sv
// filter_pkg
//   Shared definitions for the line-buffer controller of the stream filter:
//   the controller FSM encoding, the default window size and the image
//   geometry check applied when a new configuration is strobed in.
package filter_pkg;

    // Controller FSM encoding (IDLE=0, LOAD=1, RUN=2).
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } lb_state_t;

    // Default filter window size (KERNEL x KERNEL).
    localparam int KERNEL_DEF = 3;

    // A geometry is usable when a line fits in one delay_mem (and is at
    // least two pixels long), and the frame has enough lines to ever
    // produce a full window.
    function automatic logic geom_legal(input int width,
                                        input int height,
                                        input int depth,
                                        input int kernel);
        return (width >= 2) && (width <= depth) && (height >= kernel);
    endfunction

endpackage

// File: rtl/frame_pos_cnt.sv
// frame_pos_cnt
//   Column/row position counter for the pixel stream. Advances once per
//   accepted pixel, wraps the column at the end of a line and the row at the
//   end of a frame, and decodes the position flags for the current pixel.
// Ports
//   clk, rst_n   clock and synchronous active-low reset
//   clear        return to row 0, column 0 (frame abort / not running)
//   advance      a pixel is accepted at the current position this cycle
//   line_len     configured line length in pixels
//   frame_len    configured lines per frame
//   col, row     position of the pixel being accepted
//   eol/eof/sof  last pixel of line / last of frame / first of frame
//   win          a full KERNEL x KERNEL window ends at this pixel
module frame_pos_cnt #(
    parameter int MEM_AWIDTH = 8,
    parameter int CNT_WIDTH  = 12,
    parameter int KERNEL     = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  advance,
    input  logic [MEM_AWIDTH-1:0] line_len,
    input  logic [CNT_WIDTH-1:0]  frame_len,
    output logic [CNT_WIDTH-1:0]  col,
    output logic [CNT_WIDTH-1:0]  row,
    output logic                  eol,
    output logic                  eof,
    output logic                  sof,
    output logic                  win
);

    logic [CNT_WIDTH-1:0] last_col;
    logic [CNT_WIDTH-1:0] last_row;

    // Line length is zero-extended so every compare is unsigned at CNT_WIDTH.
    // Legal geometry guarantees line_len >= 2 and frame_len >= KERNEL, so the
    // decrements never underflow while running.
    assign last_col = CNT_WIDTH'(line_len) - CNT_WIDTH'(1);
    assign last_row = frame_len - CNT_WIDTH'(1);

    assign eol = (col == last_col);
    assign eof = eol && (row == last_row);
    assign sof = (col == '0) && (row == '0);
    assign win = (row >= CNT_WIDTH'(KERNEL - 1)) && (col >= CNT_WIDTH'(KERNEL - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            col <= '0;
            row <= '0;
        end else if (advance) begin
            if (eol) begin
                col <= '0;
                // End of frame rolls straight into the next frame.
                row <= eof ? '0 : row + CNT_WIDTH'(1);
            end else begin
                col <= col + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/line_buffer_ctrl.sv
// line_buffer_ctrl
//   Configures and sequences the KERNEL-1 delay_mem line buffers of a
//   KERNEL x KERNEL stream filter. A cfg_set strobe is checked for legal
//   geometry; a legal one programs every delay_mem with the line length
//   (mem_delay/mem_set) and then enables the pixel stream. Accepted pixels
//   are forwarded one cycle later together with their frame position.
// Ports
//   clk, rst_n                 clock and synchronous active-low reset
//   cfg_width, cfg_height      geometry, sampled on cfg_set
//   cfg_err, cfg_ok            last config rejected (sticky) / running
//   mem_delay, mem_set         delay broadcast and load strobe to delay_mems
//   up_data, up_val            incoming pixel stream
//   mem_data, mem_val          pixel stream into the delay_mem chain
//   up_drop                    an incoming pixel was discarded
//   dn_col, dn_row             position of the pixel on mem_data
//   dn_win, dn_sof, dn_eol, dn_eof   window-valid and frame markers
module line_buffer_ctrl
    import filter_pkg::*;
#(
    parameter int IMG_WIDTH  = 8,
    parameter int MEM_AWIDTH = 8,
    parameter int MEM_DEPTH  = 15,
    parameter int CNT_WIDTH  = 12,
    parameter int KERNEL     = KERNEL_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [MEM_AWIDTH-1:0] cfg_width,
    input  logic [CNT_WIDTH-1:0]  cfg_height,
    input  logic                  cfg_set,
    output logic                  cfg_err,
    output logic                  cfg_ok,
    output logic [MEM_AWIDTH-1:0] mem_delay,
    output logic                  mem_set,
    input  logic [IMG_WIDTH-1:0]  up_data,
    input  logic                  up_val,
    output logic [IMG_WIDTH-1:0]  mem_data,
    output logic                  mem_val,
    output logic                  up_drop,
    output logic [CNT_WIDTH-1:0]  dn_col,
    output logic [CNT_WIDTH-1:0]  dn_row,
    output logic                  dn_win,
    output logic                  dn_sof,
    output logic                  dn_eol,
    output logic                  dn_eof
);

    lb_state_t            state;
    logic [CNT_WIDTH-1:0] height_q;
    logic                 cfg_legal;
    logic                 accept;
    logic                 cnt_clear;
    logic [CNT_WIDTH-1:0] pos_col;
    logic [CNT_WIDTH-1:0] pos_row;
    logic                 pos_eol;
    logic                 pos_eof;
    logic                 pos_sof;
    logic                 pos_win;

    assign cfg_legal = geom_legal(int'(cfg_width), int'(cfg_height), MEM_DEPTH, KERNEL);

    // A configuration strobe always takes priority over a coincident pixel.
    assign accept    = (state == ST_RUN) && up_val && !cfg_set;

    // Any departure from RUN (or a reconfiguration inside it) aborts the frame.
    assign cnt_clear = (state != ST_RUN) || cfg_set;

    // Controller FSM. mem_delay/height_q only change on a legal set, so the
    // delay_mems see a stable value from the LOAD strobe onward.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            mem_delay <= '0;
            height_q  <= '0;
            mem_set   <= 1'b0;
            cfg_ok    <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            mem_set <= 1'b0;
            case (state)
                ST_IDLE, ST_RUN: begin
                    if (cfg_set) begin
                        cfg_ok <= 1'b0;
                        if (cfg_legal) begin
                            state     <= ST_LOAD;
                            mem_delay <= cfg_width;
                            height_q  <= cfg_height;
                            cfg_err   <= 1'b0;
                            mem_set   <= 1'b1;
                        end else begin
                            state   <= ST_IDLE;
                            cfg_err <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    state  <= ST_RUN;
                    cfg_ok <= 1'b1;
                end
                default: begin
                    state  <= ST_IDLE;
                    cfg_ok <= 1'b0;
                end
            endcase
        end
    end

    frame_pos_cnt #(
        .MEM_AWIDTH (MEM_AWIDTH),
        .CNT_WIDTH  (CNT_WIDTH),
        .KERNEL     (KERNEL)
    ) u_pos (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (cnt_clear),
        .advance   (accept),
        .line_len  (mem_delay),
        .frame_len (height_q),
        .col       (pos_col),
        .row       (pos_row),
        .eol       (pos_eol),
        .eof       (pos_eof),
        .sof       (pos_sof),
        .win       (pos_win)
    );

    // Output register stage. Position values hold between pixels; the flags
    // are qualified by mem_val so downstream never sees a stale marker.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_data <= '0;
            mem_val  <= 1'b0;
            up_drop  <= 1'b0;
            dn_col   <= '0;
            dn_row   <= '0;
            dn_win   <= 1'b0;
            dn_sof   <= 1'b0;
            dn_eol   <= 1'b0;
            dn_eof   <= 1'b0;
        end else begin
            mem_val <= accept;
            up_drop <= up_val && !accept;
            dn_win  <= accept && pos_win;
            dn_sof  <= accept && pos_sof;
            dn_eol  <= accept && pos_eol;
            dn_eof  <= accept && pos_eof;
            if (accept) begin
                mem_data <= up_data;
                dn_col   <= pos_col;
                dn_row   <= pos_row;
            end
        end
    end

endmodule
